md_unit: RTL and testbench

Multiply/divide unit in the EX stage. Executes mult/multu/div/divu with fixed multi-cycle latency, holds the HI/LO pair, and serves mthi/mtlo/mfhi/mflo. It produces `busy`, which the hazard logic uses together with the decoded `start` to stall HI/LO-touching instructions in D. It consumes the EX-stage `movetoE`/`movefromE` selects from the pipelined control path.

---
 rtl/md_unit.sv | 141 ++++++++++++++
 tb/tb_md_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: multi-cycle mult/multu/div/divu with a HI/LO pair,
// plus mthi/mtlo writes and a combinational mfhi/mflo read-out.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic        kill,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic [1:0]  movetoE,
   input  logic [1:0]  movefromE,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   pending_q, pending_d;
   logic          wb_q, wb_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic          accept;
   logic          moveWrite;
   logic          expire;
   logic          isSigned;
   logic [63:0]   prodS, prodU;
   logic [31:0]   divAMag, divBMag, quotMag, remMag, quot, rem;
   logic [63:0]   opResult;

   assign accept    = start & ~kill & (state_q == IDLE);
   assign moveWrite = ((movetoE == 2'b01) | (movetoE == 2'b10)) & ~kill & (state_q == IDLE) & ~accept;
   assign expire    = (state_q == RUN) && (cnt_q <= CW'(1));
   assign isSigned  = ~md_op[0];

   // Result is computed at accept time; the busy period only models the unit's latency.
   always_comb begin
      prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
      prodU = {32'b0, srcA} * {32'b0, srcB};
      divAMag = (isSigned && srcA[31]) ? (32'd0 - srcA) : srcA;
      divBMag = (isSigned && srcB[31]) ? (32'd0 - srcB) : srcB;
      quotMag = '0;
      remMag  = '0;
      if (divBMag != '0) begin
         quotMag = divAMag / divBMag;
         remMag  = divAMag % divBMag;
      end
      quot = (isSigned && (srcA[31] ^ srcB[31])) ? (32'd0 - quotMag) : quotMag;
      rem  = (isSigned && srcA[31]) ? (32'd0 - remMag) : remMag;
      case (md_op)
         2'b00:   opResult = prodS;
         2'b01:   opResult = prodU;
         default: opResult = {rem, quot};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
   end

   // A zero divisor still runs the full busy period but suppresses the HI/LO commit.
   always_comb begin
      cnt_d     = cnt_q;
      pending_d = pending_q;
      wb_d      = wb_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (accept) begin
         pending_d = opResult;
         wb_d      = ~(md_op[1] & (srcB == '0));
         cnt_d     = md_op[1] ? DIV_LOAD : MULT_LOAD;
      end else if (state_q == RUN) begin
         cnt_d = cnt_q - CW'(1);
         if (expire && wb_q) begin
            hi_d = pending_q[63:32];
            lo_d = pending_q[31:0];
         end
      end else if (moveWrite) begin
         if (movetoE == 2'b01) hi_d = srcA;
         else                  lo_d = srcA;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         pending_q <= '0;
         wb_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         wb_q      <= wb_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

   always_comb begin
      case (movefromE)
         2'b01:   md_out = hi_q;
         2'b10:   md_out = lo_q;
         default: md_out = '0;
      endcase
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized operations
// compared against a longint-arithmetic reference model of HI/LO.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  md_op;
   logic        kill;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [1:0]  movetoE;
   logic [1:0]  movefromE;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   int nCompared   = 0;
   int nMismatched = 0;
   logic [31:0] mHi, mLo;

   always #5 clk = ~clk;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .kill(kill),
      .srcA(srcA), .srcB(srcB), .movetoE(movetoE), .movefromE(movefromE),
      .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
   );

   function automatic logic [63:0] refOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] oldHi, input logic [31:0] oldLo);
      longint sa, sb;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return 64'(ua * ub);
         2'b10: if (b == 0) return {oldHi, oldLo};
                else return {32'(sa % sb), 32'(sa / sb)};
         default: if (b == 0) return {oldHi, oldLo};
                  else return {32'(ua % ub), 32'(ua / ub)};
      endcase
   endfunction

   function automatic int expCycles(input logic [1:0] op);
      return op[1] ? 10 : 5;
   endfunction

   function automatic logic [31:0] expMd(input logic [1:0] sel, input logic [31:0] h, input logic [31:0] l);
      return (sel == 2'b01) ? h : (sel == 2'b10) ? l : 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one accepted operation, records md_out in the first busy cycle, waits for completion.
   task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output logic [31:0] busyMd);
      logic [63:0] r;
      r = refOp(op, a, b, mHi, mLo);
      start = 1'b1; md_op = op; srcA = a; srcB = b;
      tick();
      start = 1'b0; srcA = $urandom(); srcB = $urandom();
      busyMd = md_out;
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         tick();
      end
      mHi = r[63:32];
      mLo = r[31:0];
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; kill = 1'b0; md_op = 2'b00;
      srcA = 32'h0; srcB = 32'h0; movetoE = 2'b00; movefromE = 2'b01;
      #12;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy got=%h want=0", busy); end
      nCompared++; if (hi !== 32'h0) begin nMismatched++; $display("FAIL reset_hi got=%h want=0", hi); end
      nCompared++; if (lo !== 32'h0) begin nMismatched++; $display("FAIL reset_lo got=%h want=0", lo); end
      nCompared++; if (md_out !== 32'h0) begin nMismatched++; $display("FAIL reset_md_out got=%h want=0", md_out); end
      mHi = 32'h0; mLo = 32'h0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_mult();
      int c;
      logic [31:0] bm;
      movefromE = 2'b10;
      runOp(2'b00, 32'hFFFFFFFD, 32'd7, c, bm);
      nCompared++; if (c !== 5) begin nMismatched++; $display("FAIL mult_busy_cycles got=%0d want=5", c); end
      nCompared++; if (hi !== 32'hFFFFFFFF) begin nMismatched++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      nCompared++; if (lo !== 32'hFFFFFFEB) begin nMismatched++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
      nCompared++; if (md_out !== 32'hFFFFFFEB) begin nMismatched++; $display("FAIL mult_md_out got=%h want=ffffffeb", md_out); end
   endtask

   task automatic test_back_to_back();
      int c;
      logic [31:0] bm;
      movefromE = 2'b10;
      runOp(2'b01, 32'hFFFFFFFF, 32'd2, c, bm);
      nCompared++; if (c !== 5) begin nMismatched++; $display("FAIL multu_busy_cycles got=%0d want=5", c); end
      nCompared++; if (hi !== 32'h00000001) begin nMismatched++; $display("FAIL multu_hi got=%h want=00000001", hi); end
      nCompared++; if (lo !== 32'hFFFFFFFE) begin nMismatched++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
      runOp(2'b10, 32'hFFFFFFF9, 32'd2, c, bm);
      nCompared++; if (bm !== 32'hFFFFFFFE) begin nMismatched++; $display("FAIL div_busy_md_out_old got=%h want=fffffffe", bm); end
      nCompared++; if (c !== 10) begin nMismatched++; $display("FAIL div_busy_cycles got=%0d want=10", c); end
      nCompared++; if (lo !== 32'hFFFFFFFD) begin nMismatched++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
      nCompared++; if (hi !== 32'hFFFFFFFF) begin nMismatched++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
   endtask

   task automatic test_div_special();
      int c;
      logic [31:0] bm;
      runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, c, bm);
      nCompared++; if (lo !== 32'h80000000) begin nMismatched++; $display("FAIL div_ovf_lo got=%h want=80000000", lo); end
      nCompared++; if (hi !== 32'h0) begin nMismatched++; $display("FAIL div_ovf_hi got=%h want=0", hi); end
      runOp(2'b11, 32'd7, 32'd0, c, bm);
      nCompared++; if (c !== 10) begin nMismatched++; $display("FAIL divu_zero_cycles got=%0d want=10", c); end
      nCompared++; if (hi !== 32'h0) begin nMismatched++; $display("FAIL divu_zero_hi got=%h want=0", hi); end
      nCompared++; if (lo !== 32'h80000000) begin nMismatched++; $display("FAIL divu_zero_lo got=%h want=80000000", lo); end
   endtask

   task automatic test_moveto();
      movetoE = 2'b01; srcA = 32'h12345678;
      tick();
      movetoE = 2'b00; srcA = 32'h0;
      mHi = 32'h12345678;
      nCompared++; if (hi !== 32'h12345678) begin nMismatched++; $display("FAIL mthi_hi got=%h want=12345678", hi); end
      movefromE = 2'b01; #1;
      nCompared++; if (md_out !== 32'h12345678) begin nMismatched++; $display("FAIL mfhi_md_out got=%h want=12345678", md_out); end
      movefromE = 2'b11; #1;
      nCompared++; if (md_out !== 32'h0) begin nMismatched++; $display("FAIL mf_reserved got=%h want=0", md_out); end
      movefromE = 2'b00; #1;
      nCompared++; if (md_out !== 32'h0) begin nMismatched++; $display("FAIL mf_none got=%h want=0", md_out); end
      movetoE = 2'b10; srcA = 32'hA5A5A5A5;
      tick();
      movetoE = 2'b00;
      mLo = 32'hA5A5A5A5;
      nCompared++; if (lo !== 32'hA5A5A5A5) begin nMismatched++; $display("FAIL mtlo_lo got=%h want=a5a5a5a5", lo); end
      movetoE = 2'b10; srcA = 32'h11111111; kill = 1'b1;
      tick();
      kill = 1'b0;
      movetoE = 2'b11; srcA = 32'h22222222;
      tick();
      movetoE = 2'b00;
      nCompared++; if (lo !== mLo) begin nMismatched++; $display("FAIL mtlo_killed_or_reserved got=%h want=%h", lo, mLo); end
      nCompared++; if (hi !== mHi) begin nMismatched++; $display("FAIL mthi_reserved got=%h want=%h", hi, mHi); end
   endtask

   task automatic test_kill();
      start = 1'b1; kill = 1'b1; md_op = 2'b00; srcA = 32'h3; srcB = 32'h5;
      tick();
      start = 1'b0; kill = 1'b0;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL kill_busy got=%h want=0", busy); end
      repeat (6) tick();
      nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL kill_hilo got=%h_%h want=%h_%h", hi, lo, mHi, mLo); end
   endtask

   task automatic test_busy_moveto();
      int c;
      logic [63:0] r;
      r = refOp(2'b00, 32'd1000, 32'hFFFFFF00, mHi, mLo);
      start = 1'b1; md_op = 2'b00; srcA = 32'd1000; srcB = 32'hFFFFFF00;
      tick();
      start = 1'b0;
      movetoE = 2'b10; srcA = 32'hDEADBEEF;
      tick(); tick();
      movetoE = 2'b00;
      c = 0;
      while (busy === 1'b1 && c < 40) begin c++; tick(); end
      mHi = r[63:32]; mLo = r[31:0];
      nCompared++; if (c >= 40) begin nMismatched++; $display("FAIL busy_moveto_timeout got=%0d want<40", c); end
      nCompared++; if (lo !== mLo) begin nMismatched++; $display("FAIL mtlo_while_busy_lo got=%h want=%h", lo, mLo); end
      nCompared++; if (hi !== mHi) begin nMismatched++; $display("FAIL mtlo_while_busy_hi got=%h want=%h", hi, mHi); end
      // start and mthi together: start wins, and divide-by-zero then leaves HI untouched
      start = 1'b1; md_op = 2'b11; srcA = 32'hCAFEF00D; srcB = 32'h0; movetoE = 2'b01;
      tick();
      start = 1'b0; movetoE = 2'b00;
      c = 0;
      while (busy === 1'b1 && c < 40) begin c++; tick(); end
      nCompared++; if (c !== 10) begin nMismatched++; $display("FAIL start_priority_cycles got=%0d want=10", c); end
      nCompared++; if (hi !== mHi) begin nMismatched++; $display("FAIL start_priority_hi got=%h want=%h", hi, mHi); end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1; md_op = 2'b00; srcA = 32'h00012345; srcB = 32'h00067890;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL midrun_reset_busy got=%h want=0", busy); end
      nCompared++; if (hi !== 32'h0 || lo !== 32'h0) begin nMismatched++; $display("FAIL midrun_reset_hilo got=%h_%h want=0_0", hi, lo); end
      mHi = 32'h0; mLo = 32'h0;
      tick();
      reset = 1'b1;
      repeat (8) tick();
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("FAIL post_reset_busy got=%h want=0", busy); end
      nCompared++; if (hi !== 32'h0 || lo !== 32'h0) begin nMismatched++; $display("FAIL post_reset_commit got=%h_%h want=0_0", hi, lo); end
   endtask

   task automatic test_random();
      int c;
      logic [31:0] bm, a, b, oldMd;
      logic [1:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 9));
            3: a = 32'($urandom_range(0, 100));
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) begin
            movetoE = 2'($urandom_range(1, 2)); srcA = $urandom();
            if (movetoE == 2'b01) mHi = srcA; else mLo = srcA;
            tick();
            movetoE = 2'b00;
         end
         movefromE = 2'($urandom_range(0, 3));
         oldMd = expMd(movefromE, mHi, mLo);
         runOp(op, a, b, c, bm);
         nCompared++; if (bm !== oldMd) begin nMismatched++; $display("FAIL rnd%0d_busy_md_out got=%h want=%h", i, bm, oldMd); end
         nCompared++; if (c !== expCycles(op)) begin nMismatched++; $display("FAIL rnd%0d_cycles op=%0d got=%0d want=%0d", i, op, c, expCycles(op)); end
         nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, op, a, b, hi, lo, mHi, mLo); end
         nCompared++; if (md_out !== expMd(movefromE, mHi, mLo)) begin nMismatched++; $display("FAIL rnd%0d_md_out got=%h want=%h", i, md_out, expMd(movefromE, mHi, mLo)); end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_back_to_back();
      test_div_special();
      test_moveto();
      test_kill();
      test_busy_moveto();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
